// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl
// Purpose  : Issue/writeback controller sitting between the execute stage and
//            the multiply/divide units. Accepts one request at a time and
//            holds its operands for the whole operation. It fires a one-cycle
//            start pulse, then waits for the unit's ready flag, with a
//            timeout. The result, destination tag and exception flag are then
//            presented to writeback until they are consumed.
// Ports    : clock, reset_n               - rising-edge clock, async active-low reset
//            req_valid/req_ready          - request handshake
//            req_is_div, req_a/b, req_rd  - request payload
//            flush                        - kill any in-flight op
//            op_a, op_b                   - held operands to the unit
//            ctrl_MULT, ctrl_DIV          - one-cycle start pulses
//            unit_result/exception/RDY    - unit response
//            wb_valid/wb_ready            - writeback handshake
//            wb_data, wb_rd, wb_exception - writeback payload
//            busy                         - stall: high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int RD_W     = 5,
    parameter int TIMEOUT  = 40,
    parameter int MIN_WAIT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_div,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [RD_W-1:0]  req_rd,
    input  logic             flush,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    input  logic [WIDTH-1:0] unit_result,
    input  logic             unit_exception,
    input  logic             unit_resultRDY,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_exception,
    output logic             busy
);

    // One spare bit so that the post-timeout increment can never wrap.
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             is_div;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             rdy_ok;
    logic             timed_out;

    // RDY is only trusted once the unit has had MIN_WAIT cycles to drop any
    // ready flag left over from a previous operation.
    assign rdy_ok    = (state == S_WAIT) && unit_resultRDY
                       && (count >= CNT_W'(MIN_WAIT));
    assign timed_out = (state == S_WAIT) && (count == CNT_W'(TIMEOUT - 1));
    // A flushed request is dropped even though req_ready is shown high.
    assign accept    = req_valid && req_ready && !flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;
        wb_valid   = 1'b0;
        busy       = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                // Suppressed under flush so a killed op never starts the unit.
                ctrl_MULT  = !is_div && !flush;
                ctrl_DIV   = is_div && !flush;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (rdy_ok || timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                wb_valid  = 1'b1;
                req_ready = wb_ready;
                if (wb_ready) begin
                    // Back-to-back issue skips IDLE entirely.
                    state_next = req_valid ? S_START : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (flush) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a         <= '0;
            op_b         <= '0;
            wb_rd        <= '0;
            is_div       <= 1'b0;
            count        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= req_a;
                op_b   <= req_b;
                wb_rd  <= req_rd;
                is_div <= req_is_div;
            end

            if (state == S_START) begin
                count <= '0;
            end else if (state == S_WAIT) begin
                count <= count + 1'b1;
            end

            // A real result wins over a timeout landing in the same cycle.
            if (!flush) begin
                if (rdy_ok) begin
                    wb_data      <= unit_result;
                    wb_exception <= unit_exception;
                end else if (timed_out) begin
                    wb_data      <= '0;
                    wb_exception <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_issue_ctrl
// Purpose  : Self-checking bench for multdiv_issue_ctrl. A transaction-level
//            model tracks the pending pulse, the elapsed wait and the held
//            result, and every cycle's outputs are compared against it.
//            Directed scenarios pin the model to hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

    localparam int WIDTH    = 32;
    localparam int RD_W     = 5;
    localparam int TIMEOUT  = 40;
    localparam int MIN_WAIT = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_is_div = 1'b0;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [RD_W-1:0]  req_rd = '0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] unit_result = '0;
    logic             unit_exception = 1'b0;
    logic             unit_resultRDY = 1'b0;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [WIDTH-1:0] wb_data;
    logic [RD_W-1:0]  wb_rd;
    logic             wb_exception;
    logic             busy;

    multdiv_issue_ctrl #(
        .WIDTH   (WIDTH),
        .RD_W    (RD_W),
        .TIMEOUT (TIMEOUT),
        .MIN_WAIT(MIN_WAIT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_div    (req_is_div),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_rd        (req_rd),
        .flush         (flush),
        .op_a          (op_a),
        .op_b          (op_b),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .unit_result   (unit_result),
        .unit_exception(unit_exception),
        .unit_resultRDY(unit_resultRDY),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_exception  (wb_exception),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int n_mult = 0;
    int n_div = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pulse_due : op accepted, start pulse is shown this cycle
    // waiting   : pulse issued, m_elapsed cycles of waiting so far
    // have_res  : result is being offered to writeback
    bit               m_pulse = 1'b0;
    bit               m_wait = 1'b0;
    bit               m_valid = 1'b0;
    bit               m_div = 1'b0;
    bit               m_exc = 1'b0;
    int               m_elapsed = 0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic [WIDTH-1:0] m_data = '0;
    logic [RD_W-1:0]  m_rd = '0;

    always @(posedge clock or negedge reset_n) begin : model
        bit               p, w, v, x, take;
        int               e;
        logic [WIDTH-1:0] d;
        if (!reset_n) begin
            m_pulse <= 1'b0; m_wait <= 1'b0; m_valid <= 1'b0; m_div <= 1'b0;
            m_exc <= 1'b0; m_elapsed <= 0; m_a <= '0; m_b <= '0;
            m_data <= '0; m_rd <= '0;
        end else begin
            p = m_pulse; w = m_wait; v = m_valid; e = m_elapsed;
            d = m_data; x = m_exc; take = 1'b0;
            if (flush) begin
                p = 1'b0; w = 1'b0; v = 1'b0;
            end else if (m_pulse) begin
                p = 1'b0; w = 1'b1; e = 0;
            end else if (m_wait) begin
                if (unit_resultRDY && e >= MIN_WAIT) begin
                    w = 1'b0; v = 1'b1; d = unit_result; x = unit_exception;
                end else if (e == TIMEOUT - 1) begin
                    w = 1'b0; v = 1'b1; d = '0; x = 1'b1;
                end else begin
                    e = e + 1;
                end
            end else if (m_valid) begin
                if (wb_ready) begin
                    v = 1'b0;
                    take = req_valid;
                end
            end else begin
                take = req_valid;
            end
            if (take) p = 1'b1;
            m_pulse <= p; m_wait <= w; m_valid <= v; m_elapsed <= e;
            m_data <= d; m_exc <= x;
            if (take) begin
                m_a <= req_a; m_b <= req_b; m_rd <= req_rd; m_div <= req_is_div;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin : compare
        bit e_busy;
        if (reset_n) begin
            e_busy = m_pulse || m_wait || m_valid;
            chk("busy", busy, e_busy);
            chk("req_ready", req_ready, !e_busy || (m_valid && wb_ready));
            chk("ctrl_MULT", ctrl_MULT, m_pulse && !m_div && !flush);
            chk("ctrl_DIV", ctrl_DIV, m_pulse && m_div && !flush);
            chk("wb_valid", wb_valid, m_valid);
            chk("wb_data", wb_data, m_data);
            chk("wb_exception", wb_exception, m_exc);
            chk("wb_rd", wb_rd, m_rd);
            chk("op_a", op_a, m_a);
            chk("op_b", op_b, m_b);
            if (ctrl_MULT) n_mult++;
            if (ctrl_DIV) n_div++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input bit div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [RD_W-1:0] rd);
        chk("issue_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_is_div = div; req_a = a; req_b = b; req_rd = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // Called in the START cycle (n=0). RDY is raised in cycle n==rdy_at and
    // n==spur_at (spurious, garbage payload). lat = cycles until wb_valid.
    task automatic await_wb(input int rdy_at, input logic [WIDTH-1:0] res, input bit exc,
                            input int spur_at, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 80 && lat < 0) begin
            unit_resultRDY = (n == rdy_at) || (n == spur_at);
            unit_result    = (n == rdy_at) ? res : 32'hdead_beef;
            unit_exception = (n == rdy_at) ? exc : 1'b1;
            tick();
            n++;
            if (wb_valid) lat = n;
        end
        unit_resultRDY = 1'b0;
        unit_result    = '0;
        unit_exception = 1'b0;
        if (lat < 0) chk("await_bound", 1'b0, 1'b1);
    endtask

    task automatic release_wb();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    // ---------------- main ----------------
    initial begin : main
        int lat, bm, bd;
        #1 reset_n = 1'b0;
        #11;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_pulses", {ctrl_MULT, ctrl_DIV}, 2'b00);
        chk("rst_op_a", op_a, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_exc", wb_exception, 1'b0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        // 1: div 100/7, RDY 33 cycles after the pulse
        bm = n_mult; bd = n_div;
        issue(1'b1, 32'd100, 32'd7, 5'd5);
        chk("t1_ctrl_DIV", ctrl_DIV, 1'b1);
        await_wb(33, 32'd14, 1'b0, -1, lat);
        chk("t1_lat", lat, 34);
        chk("t1_wb_data", wb_data, 32'd14);
        chk("t1_wb_rd", wb_rd, 5'd5);
        chk("t1_wb_exc", wb_exception, 1'b0);
        tick();
        chk("t1_busy_held", busy, 1'b1);
        chk("t1_div_pulses", n_div - bd, 1);
        chk("t1_mult_pulses", n_mult - bm, 0);
        release_wb();
        chk("t1_busy_after", busy, 1'b0);

        // 2: div by zero reported by the unit
        issue(1'b1, 32'd9, 32'd0, 5'd2);
        await_wb(10, 32'd0, 1'b1, -1, lat);
        chk("t2_wb_exc", wb_exception, 1'b1);
        chk("t2_wb_data", wb_data, 32'd0);
        release_wb();

        // 3: mult 6*7, spurious RDY at WAIT count 0, real at count 5
        bd = n_div;
        issue(1'b0, 32'd6, 32'd7, 5'd12);
        chk("t3_ctrl_MULT", ctrl_MULT, 1'b1);
        await_wb(6, 32'd42, 1'b0, 1, lat);
        chk("t3_lat", lat, 7);
        chk("t3_wb_data", wb_data, 32'd42);
        chk("t3_no_div", n_div - bd, 0);
        release_wb();

        // 4: no RDY ever -> timeout
        issue(1'b0, 32'd3, 32'd3, 5'd1);
        await_wb(-1, 32'd0, 1'b0, -1, lat);
        chk("t4_lat", lat, TIMEOUT + 1);
        chk("t4_wb_data", wb_data, 32'd0);
        chk("t4_wb_exc", wb_exception, 1'b1);
        release_wb();

        // 5: hold in DONE, then back-to-back accept
        issue(1'b0, 32'd3, 32'd5, 5'd9);
        await_wb(4, 32'd15, 1'b0, -1, lat);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_valid", wb_valid, 1'b1);
            chk("t5_hold_data", wb_data, 32'd15);
            chk("t5_hold_rd", wb_rd, 5'd9);
        end
        wb_ready = 1'b1;
        req_valid = 1'b1; req_is_div = 1'b0; req_a = 32'd11; req_b = 32'd12; req_rd = 5'd3;
        #1;
        chk("t5_ready_in_done", req_ready, 1'b1);
        tick();
        req_valid = 1'b0; wb_ready = 1'b0;
        chk("t5_b2b_pulse", ctrl_MULT, 1'b1);
        chk("t5_b2b_busy", busy, 1'b1);
        chk("t5_b2b_op_a", op_a, 32'd11);
        await_wb(3, 32'd132, 1'b0, -1, lat);
        chk("t5_min_lat", lat, MIN_WAIT + 2);
        chk("t5_wb_data", wb_data, 32'd132);
        release_wb();

        // 6a: flush in WAIT, then a late RDY
        issue(1'b1, 32'd50, 32'd5, 5'd7);
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_busy", busy, 1'b0);
        bm = n_mult; bd = n_div;
        unit_resultRDY = 1'b1; unit_result = 32'd10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_wb_valid", wb_valid, 1'b0);
        end
        unit_resultRDY = 1'b0;
        chk("t6_no_pulse", (n_mult - bm) + (n_div - bd), 0);

        // 6b: async reset while in START
        issue(1'b1, 32'd77, 32'd4, 5'd30);
        chk("t6_start_pulse", ctrl_DIV, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_ctrl_DIV", ctrl_DIV, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ready", req_ready, 1'b1);
        chk("t6_rst_op_a", op_a, 0);
        chk("t6_rst_wb_rd", wb_rd, 0);
        chk("t6_rst_wb_data", wb_data, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        // random phase against the model
        for (int i = 0; i < 3000; i++) begin
            req_valid      = ($urandom_range(0, 1) == 1);
            req_is_div     = $urandom_range(0, 1) == 1;
            req_a          = $urandom;
            req_b          = $urandom;
            req_rd         = RD_W'($urandom);
            flush          = ($urandom_range(0, 99) < 3);
            wb_ready       = ($urandom_range(0, 99) < 60);
            unit_resultRDY = ($urandom_range(0, 99) < (i < 1500 ? 15 : 2));
            unit_result    = $urandom;
            unit_exception = $urandom_range(0, 1) == 1;
            tick();
        end
        req_valid = 1'b0; flush = 1'b0; unit_resultRDY = 1'b0; wb_ready = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
